// File: rtl/systolic_pkg.sv
// systolic_pkg: shared sizes, element type and skewer state encoding for the systolic datapath.
package systolic_pkg;
  localparam int WIDTH = 16;
  localparam int SIZE = 10;
  localparam int FRAME_BEATS = 2 * SIZE - 1;
  typedef logic signed [WIDTH-1:0] elem_t;
  typedef enum logic {IDLE, STREAM} skew_state_e;
endpackage

// File: rtl/systolic_input_skewer_tile_buffer.sv
// tile_buffer: SIZE x SIZE element register array with load enable and a full flag.
module tile_buffer #(
  parameter int WIDTH = systolic_pkg::WIDTH,
  parameter int SIZE = systolic_pkg::SIZE
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] d,
  output logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] q,
  output logic full
);
  import systolic_pkg::*;
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
      full <= 1'b0;
    end else if (load) begin
      q <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/systolic_input_skewer.sv
// systolic_input_skewer: buffers one tile and streams it as diagonally skewed lanes; SKEWER_DOUBLE_BUFFER_EN adds a shadow tile for gapless frames.
module systolic_input_skewer #(
  parameter int WIDTH = systolic_pkg::WIDTH,
  parameter int SIZE = systolic_pkg::SIZE
) (
  input  logic clk,
  input  logic reset,
  input  logic load_valid,
  output logic load_ready,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] load_matrix,
  input  logic stall,
  output logic signed [SIZE-1:0][WIDTH-1:0] skew_data,
  output logic [SIZE-1:0] skew_valid,
  output logic frame_first,
  output logic frame_last
);
  import systolic_pkg::*;
  localparam int TW = $clog2(2 * SIZE);
  localparam logic [TW-1:0] LAST_T = TW'(2 * SIZE - 2);
  skew_state_e state;
  logic [TW-1:0] t, nt;
  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] active_q, shadow_q, src;
  logic active_full, shadow_full, accept, last, start;
  logic [SIZE-1:0][WIDTH-1:0] nxt_data;
  logic [SIZE-1:0] nxt_valid;
  assign accept = load_valid && load_ready;
  assign last = state == STREAM && active_full && !stall && t == LAST_T;
  // a new frame starts from idle, or back-to-back when the last beat is consumed
  assign start = (accept && (state == IDLE || last)) || (last && shadow_full);
  assign src = start ? (accept ? load_matrix : shadow_q) : active_q;
  assign nt = start ? '0 : t + 1'b1;
  tile_buffer #(.WIDTH(WIDTH), .SIZE(SIZE)) u_active (
    .clk(clk), .reset(reset), .load(start), .clear(last && !start),
    .d(src), .q(active_q), .full(active_full)
  );
`ifdef SKEWER_DOUBLE_BUFFER_EN
  tile_buffer #(.WIDTH(WIDTH), .SIZE(SIZE)) u_shadow (
    .clk(clk), .reset(reset), .load(accept && state == STREAM && !last),
    .clear(last && shadow_full), .d(load_matrix), .q(shadow_q), .full(shadow_full)
  );
  assign load_ready = !reset && (state == IDLE || !shadow_full);
`else
  assign shadow_q = '0;
  assign shadow_full = 1'b0;
  assign load_ready = !reset && state == IDLE;
`endif
  // lane r carries column t-r of row r while that falls inside the tile
  always_comb begin
    nxt_data = '0;
    nxt_valid = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        if (int'(nt) == r + c) begin
          nxt_data[r] = src[r][c];
          nxt_valid[r] = 1'b1;
        end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      t <= '0;
      skew_data <= '0;
      skew_valid <= '0;
      frame_first <= 1'b0;
      frame_last <= 1'b0;
    end else if (start || (state == STREAM && !stall && !last)) begin
      state <= STREAM;
      t <= nt;
      skew_data <= nxt_data;
      skew_valid <= nxt_valid;
      frame_first <= nt == '0;
      frame_last <= nt == LAST_T;
    end else if (last) begin
      state <= IDLE;
      t <= '0;
      skew_data <= '0;
      skew_valid <= '0;
      frame_first <= 1'b0;
      frame_last <= 1'b0;
    end
  end
endmodule

// File: tb/tb_systolic_input_skewer.sv
// tb_systolic_input_skewer: scoreboard bench for systolic_input_skewer; follows SKEWER_DOUBLE_BUFFER_EN when defined.
module tb_systolic_input_skewer;
  import systolic_pkg::*;
  localparam int W = WIDTH;
  localparam int S = SIZE;
  localparam int FB = FRAME_BEATS;
`ifdef SKEWER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  typedef struct packed {
    logic [S-1:0][W-1:0] d;
    logic [S-1:0] v;
    logic f;
    logic l;
  } beat_t;
  logic clk = 1'b0;
  logic reset, load_valid, load_ready, stall, frame_first, frame_last;
  logic [S-1:0][S-1:0][W-1:0] tile;
  logic signed [S-1:0][W-1:0] skew_data;
  logic [S-1:0] skew_valid;
  beat_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  systolic_input_skewer #(.WIDTH(W), .SIZE(S)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_matrix(tile), .stall(stall), .skew_data(skew_data), .skew_valid(skew_valid),
    .frame_first(frame_first), .frame_last(frame_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic beat_t make_beat(input int t);
    beat_t b = '0;
    for (int r = 0; r < S; r++) begin
      int j = t - r;
      if (j >= 0 && j < S) begin
        b.d[r] = tile[r][j];
        b.v[r] = 1'b1;
      end
    end
    b.f = t == 0;
    b.l = t == FB - 1;
    return b;
  endfunction

  task automatic push_frame();
    for (int t = 0; t < FB; t++) q.push_back(make_beat(t));
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        elem_t e;
        e = mode == 0 ? elem_t'(10 * i + 10 * j) : mode == 1 ? (i < 5 ? 16'sd1 : -16'sd1) : elem_t'($urandom);
        tile[i][j] = e;
      end
  endtask

  // one clock: drive inputs, check ready before the edge, update the model, check beat after it
  task automatic step(input logic st, input logic lv);
    logic mready;
    stall = st;
    load_valid = lv;
    #1;
    mready = !reset && (DB ? q.size() <= FB : q.size() == 0);
    chk("load_ready", 256'(load_ready), 256'(mready));
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (q.size() > 0 && !st) void'(q.pop_front());
      if (lv && mready) push_frame();
    end
    #1;
    cyc++;
    chk("beat", 256'({skew_data, skew_valid, frame_first, frame_last}),
        256'(q.size() > 0 ? q[0] : beat_t'('0)));
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    load_valid = 1'b0;
    tile = '0;
    step(0, 0);
    step(1, 1);
    reset = 1'b0;
    fill(0);
    step(0, 1);
    for (int k = 1; k < FB; k++) begin
      step(0, 0);
      if (k == 3) chk("lane3_t3", 256'({skew_valid[3], skew_data[3]}), 256'({1'b1, 16'd30}));
      if (k == 12) chk("lane3_t12", 256'({skew_valid[3], skew_data[3]}), 256'({1'b1, 16'd120}));
      if (k == 13) chk("lane3_t13", 256'({skew_valid[3], skew_data[3]}), 256'(0));
      if (k == FB - 1) chk("frame_last_t18", 256'(frame_last), 256'(1));
    end
    step(0, 0);
    fill(1);
    step(0, 1);
    for (int k = 1; k < FB; k++) begin
      step(0, 0);
      if (k == 7) chk("lane7_t7", 256'({skew_valid[7], skew_data[7]}), 256'({1'b1, 16'hFFFF}));
      if (k == 17) chk("lane7_t17", 256'({skew_valid[7], skew_data[7]}), 256'(0));
    end
    step(0, 0);
    fill(0);
    step(0, 1);
    for (int i = 0; i < FB + 3; i++) begin
      step(i >= 5 && i < 8, 0);
      if (i == 17) chk("no_early_last", 256'(frame_last), 256'(0));
      if (i == 20) chk("stalled_last", 256'(frame_last), 256'(1));
    end
    fill(0);
    step(0, 1);
    for (int k = 1; k <= 8; k++) step(0, 0);
    reset = 1'b1;
    step(0, 0);
    reset = 1'b0;
    fill(1);
    step(0, 1);
    for (int k = 1; k <= FB; k++) step(0, 0);
    fill(0);
    for (int i = 0; i < FB + 3; i++) step(0, 1);
    for (int i = 0; i < FB + 1; i++) step(0, 0);
    fill(0);
    step(0, 1);
    for (int k = 1; k <= 4; k++) step(0, 0);
    fill(1);
    step(0, 1);
    fill(2);
    for (int i = 0; i < 2 * FB + 2; i++) step(0, 0);
    for (int i = 0; i < 120; i++) begin
      fill(2);
      step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3 * FB; i++) step(0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_input_skewer.md
Name: systolic_input_skewer

Overview:
- Upstream feeder for systolic_array.
- Accepts one SIZE×SIZE signed activation tile via a valid/ready load handshake and buffers it.
- Streams the tile as per-row diagonally skewed lanes: lane r delayed r cycles, zero-padded outside its window.
- Provides the wavefront timing the array's PE rows require.

Parameters:
- WIDTH, 16, signed element width (matches systolic_array WIDTH)
- SIZE, 10, tile dimension and lane count

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset, sampled on rising clk
- load_valid  input  1  load_matrix holds a valid tile
- load_ready  output  1  block can accept a tile this cycle
- load_matrix  input  SIZE×SIZE×WIDTH signed  tile, [row][col]
- stall  input  1  downstream hold; current beat is not consumed
- skew_data  output  SIZE×WIDTH signed  per-lane element, registered
- skew_valid  output  SIZE  per-lane valid, registered
- frame_first  output  1  high with beat t=0
- frame_last  output  1  high with beat t=2*SIZE-2

Behaviour:
- Reset (sync, priority over everything): state=IDLE, beat counter t=0, skew_data all 0, skew_valid 0, frame_first/frame_last 0, buffers marked empty. load_ready=0 while reset high.
- Reset mid-frame aborts the frame; buffered data is discarded.
- States:
  - IDLE: load_ready=1, outputs 0. On load_valid&&load_ready, capture tile, go to STREAM with t=0.
  - STREAM: emit one beat per cycle.
- Latency: the handshake cycle is followed on the next cycle by beat t=0 on the registered outputs.
- Beat t (0..2*SIZE-2):
  - lane r: skew_data[r]=tile[r][t-r] and skew_valid[r]=1 when 0 ≤ t-r ≤ SIZE-1; otherwise skew_data[r]=0 and skew_valid[r]=0.
  - Frame is exactly 2*SIZE-1 beats.
- Beat consumption:
  - A beat is consumed on a cycle with stall=0.
  - stall=1 holds t and all outputs, including frame_first/frame_last, unchanged.
  - stall in IDLE has no effect.
- After the last beat is consumed: return to IDLE, outputs 0 next cycle (unless a double-buffered tile is pending).
- Counter width: $clog2(2*SIZE). No wrap beyond 2*SIZE-2.
- Base build: load_ready=0 during STREAM; load_valid is ignored.
- No arithmetic: values pass bit-exact, sign preserved.
- Zero padding is 0 with valid low; downstream may use either.

Optional Feature:
- Macro: SKEWER_DOUBLE_BUFFER_EN.
- When defined:
  - Adds a shadow tile buffer; load_ready=1 in STREAM whenever the shadow is empty.
  - When the last beat is consumed and the shadow is full: the shadow is promoted to active, t=0 next cycle, frame_first high. No idle gap between frames.
  - A load accepted on the same cycle the last beat is consumed: the tile goes straight to active, with beat t=0 next cycle.
  - Reset clears both buffers.
- When undefined: single buffer, behaviour as above, with a minimum 1 idle cycle between frames.

Decomposition:
- Package systolic_pkg:
  - default WIDTH/SIZE constants
  - elem_t (logic signed [WIDTH-1:0])
  - skew_state_e enum {IDLE, STREAM}
  - FRAME_BEATS = 2*SIZE-1
- Sub-module tile_buffer: SIZE×SIZE register array with load enable and full flag. Instantiated once, or twice under SKEWER_DOUBLE_BUFFER_EN.

Test Plan:
- Basic skew, no stall, SIZE=10, tile[i][j]=10*i+10*j:
  - lane 0 = 0,10,…,90 at t=0..9
  - lane 3 invalid at t=0..2, 30 at t=3, 120 at t=12, invalid/0 at t=13
  - frame_last at t=18
  - load_ready back to 1 the cycle after
- Signed data, tile rows 0-4 = +1 and rows 5-9 = -1: lane 7 emits -1 (0xFFFF) with valid at t=7..16 only.
- stall=1 for 3 cycles at t=5: outputs frozen for 3 cycles; frame still 19 consumed beats; frame_last occurs 3 cycles later than unstalled.
- Reset asserted at t=8, held 1 cycle: next cycle all outputs 0, state IDLE, load_ready=1. A new tile loads and starts cleanly at t=0.
- load_valid held high during STREAM (base build): ignored, load_ready=0. Second tile accepted only after frame_last is consumed.
- SKEWER_DOUBLE_BUFFER_EN, second tile presented at t=4: accepted; its t=0 beat follows the first frame's t=18 with zero gap; frame_first high on that beat.
